// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial transmitter.
// Optional parity build: define SERIAL_TX_PARITY_EN.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned SERIAL_DATA_W       = 8;
  localparam int unsigned SERIAL_CLKS_PER_BIT = 4;

  // A one-cycle bit period still needs a 1-bit counter.
  function automatic int unsigned timer_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Wraps to zero on its own terminal count, so every state entry that follows a tick starts at zero.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   TW   = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter: start bit, data bits, optional even parity, stop bit.
// Parity state is compiled in only when SERIAL_TX_PARITY_EN is defined.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = SERIAL_DATA_W,
  parameter int unsigned CLKS_PER_BIT = SERIAL_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   CW       = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic              tick;
  logic              accept;
  logic              timer_clear;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign accept      = (state_q == IDLE) && valid;
  // Held clear while idle; later states are entered on a tick, when the timer wraps to zero.
  assign timer_clear = (state_q == IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (valid) state_d = START;
      START:  if (tick)  state_d = DATA;
      DATA: begin
        if (tick && (bitcnt_q == LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (tick)  state_d = STOP;
`endif
      STOP:   if (tick)  state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      shreg_d = data_in;
    end else if ((state_q == DATA) && tick) begin
      shreg_d  = shreg_q >> 1;
      bitcnt_d = bitcnt_q + 1'b1;
    end
    if (state_q == START) bitcnt_d = '0;
  end

`ifdef SERIAL_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (accept) par_d = ^data_in;
  end
`endif

  always_comb begin
    tx    = 1'b1;
    ready = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      START:  tx   = 1'b0;
      DATA:   tx   = shreg_q[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: tx   = par_q;
`endif
      STOP:   done = tick;
      default: ;
    endcase
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line as a framed, LSB-first bitstream: start bit, data bits, optional parity, stop bit. It drives the line side of the project's serial link, opposite the capture/storage element that samples `tx`, and is the block the benches use to generate serial stimulus.

## Interface
- `DATA_W`, 8: data bits per frame; legal range is 1 or more.
- `CLKS_PER_BIT`, 4: `clk` cycles per transmitted bit; legal range is 1 or more.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `data_in` input, `DATA_W`: word to send; sampled only on the accept edge.
- `valid` input, 1: `data_in` is valid.
- `ready` output, 1: block can accept a word.
- `tx` output, 1: serial line; idles high.
- `busy` output, 1: a frame is in progress.
- `done` output, 1: one-cycle pulse at the end of a frame.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `ready`=1, `tx`=1, `busy`=0.
  - On `valid && ready` at a rising edge: latch `data_in` into the shift register and go to START.
  - `data_in` changing after acceptance has no effect on the frame in flight.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles, shift right by one and increment the bit counter.
  - After `DATA_W` bits, go to PARITY if enabled, otherwise STOP.
- PARITY: `tx` = XOR of the latched word (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - `done`=1 during the final STOP cycle only.
  - Then go to IDLE.
- `ready` is 0 in every state except IDLE; `valid` outside IDLE is ignored.
- `busy` = (state != IDLE).
- Bit timer:
  - Counts 0..`CLKS_PER_BIT`-1, width `$clog2(CLKS_PER_BIT)` with a minimum of 1.
  - Clears on state entry.
  - Its terminal count advances the FSM.
- Bit counter:
  - Width `$clog2(DATA_W)+1`.
  - Clears on entry to DATA.
  - No wrap is observable.
- `CLKS_PER_BIT`=1: every state lasts exactly one cycle; this must work.

## Timing
- Reset values: `tx`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, counters 0.
- Reset mid-frame:
  - Asynchronously forces IDLE and `tx`=1 in the same instant; the frame is dropped.
  - No `done` pulse is issued for the dropped frame.
- Define frame length F = (`DATA_W`+2+P)×`CLKS_PER_BIT` cycles, where P=1 with parity and 0 without.
- Accept at edge k:
  - `tx` falls after edge k.
  - `tx` is high again after edge k+`CLKS_PER_BIT`×(1+`DATA_W`+P).
  - `done` is high in the cycle ending at edge k+F.
  - `ready`=1 after edge k+F.
- Back-to-back operation:
  - With `valid` held high, the next accept occurs at edge k+F+1.
  - Frame period is therefore F+1 cycles, with exactly one idle-high cycle between frames.
- Outputs `tx`, `busy` and `done` are registered, or decoded from registered state only; no combinational path from inputs to outputs except none.
- `ready` is decoded from state only.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - PARITY state is compiled in and P=1.
  - Parity is even: XOR of all data bits.
- Not defined:
  - No PARITY state and P=0.
  - DATA goes directly to STOP.

## Structure
- Package `serial_pkg` contains:
  - `typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t`.
  - Default constants `SERIAL_DATA_W`=8 and `SERIAL_CLKS_PER_BIT`=4.
- Sub-module `bit_timer` (parameter `CLKS_PER_BIT`):
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `tick`, high on terminal count.
  - Instantiated once.

## Test plan
- Reset held 3 cycles, then released with `valid`=0 → `tx`=1, `ready`=1, `busy`=0, `done`=0 throughout.
- `DATA_W`=8, `CLKS_PER_BIT`=4, send 8'hA5 → `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,(parity 0),1.
  - Without parity, `done` pulses at cycle 40 after accept.
  - With parity, `done` pulses at cycle 44 after accept.
- `valid` held high with data 8'h00 then 8'hFF → two frames with exactly one idle-high cycle between them.
  - With parity enabled, the parity bit is 0 for both frames.
- `data_in` changed to 8'h3C one cycle after accepting 8'hC3 → serial output still carries 8'hC3.
- `reset` asserted during DATA bit 3 → `tx`=1 immediately and `busy`=0, with no `done` pulse.
  - After release, the next frame is transmitted correctly.
- `CLKS_PER_BIT`=1, send 8'h81 → 10 or 11 consecutive single-cycle bits (without/with parity).
  - `done` is asserted in the final cycle of the frame.
